transpose_stream_ctrl: RTL

- Element-serial matrix transpose sequencer for the pseudo-inverse datapath.
- Accepts an M×N matrix one element per cycle in row-major order over a valid/ready input, and buffers it.
- Replays the buffer in transposed order (row-major of the N×M result) over a valid/ready output.
- Exposes the full transposed matrix as a packed bus for downstream combinational stages (multiplier, inverse).

---
 rtl/transpose_stream_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/transpose_stream_ctrl.sv
// transpose_stream_ctrl
// Element-serial matrix transpose sequencer. An M x N matrix arrives one
// element per cycle in row-major order, is buffered, then replayed in
// row-major order of the N x M transpose. The whole transpose is also
// exposed as a packed bus, with element (0,0) in the MSBs.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data/in_valid/in_ready      element input handshake (LOAD only)
//   out_data/out_valid/out_ready   transposed element output (DRAIN only)
//   out_last          final element B[N-1][M-1] is on out_data
//   mat_out           packed transposed matrix B (N x M)
//   mat_done          one-cycle pulse on the first DRAIN cycle
//   busy              high while draining
module transpose_stream_ctrl #(
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int nBits = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [nBits-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [nBits-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [N*M*nBits-1:0]     mat_out,
    output logic                     mat_done,
    output logic                     busy
);
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(M - 1);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic {LOAD, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     r_q, r_d, l_q, l_d;   // row counters (load / drain)
    logic [CW-1:0]     c_q, c_d, k_q, k_d;   // column counters (load / drain)
    logic              done_q, done_d;
    logic [nBits-1:0]  a_q [M][N];
    logic              in_acc, out_acc;

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        k_d       = k_q;
        l_d       = l_q;
        done_d    = 1'b0;
        // in_ready masked by rst so nothing looks acceptable during reset
        in_ready  = (state_q == LOAD) && !rst;
        out_valid = (state_q == DRAIN);
        busy      = (state_q == DRAIN);
        out_last  = (state_q == DRAIN) && (k_q == C_LAST) && (l_q == R_LAST);
        in_acc    = in_valid && in_ready;
        out_acc   = out_valid && out_ready;
        case (state_q)
            LOAD: begin
                if (in_acc) begin
                    if (c_q == C_LAST) begin
                        c_d = '0;
                        if (r_q == R_LAST) begin
                            r_d     = '0;
                            state_d = DRAIN;
                            done_d  = 1'b1;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_acc) begin
                    if (l_q == R_LAST) begin
                        l_d = '0;
                        if (k_q == C_LAST) begin
                            k_d     = '0;
                            state_d = LOAD;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end else begin
                        l_d = l_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            l_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            l_q     <= l_d;
            done_q  <= done_d;
        end
    end

    // Element buffer A[i][j]
    always_ff @(posedge clk) begin
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                if (rst)
                    a_q[i][j] <= '0;
                else if (in_acc && r_q == RW'(i) && c_q == CW'(j))
                    a_q[i][j] <= in_data;
            end
        end
    end

    // Drain read: B[k][l] = A[l][k]
    always_comb begin
        out_data = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                if (l_q == RW'(i) && k_q == CW'(j))
                    out_data = a_q[i][j];
            end
        end
    end

    // Packed transpose: B is N x M, B(k,l) at flat index k*M+l from the MSB end
    for (genvar k = 0; k < N; k++) begin : g_col
        for (genvar l = 0; l < M; l++) begin : g_row
            assign mat_out[(N*M - (k*M + l))*nBits - 1 -: nBits] = a_q[l][k];
        end
    end

    assign mat_done = done_q;

endmodule
